// File: rtl/instruction_fetch_decode.sv
// ---------------------------------------------------------------------------
// Module : instruction_fetch_decode
// Multi-cycle fetch/decode/exec sequencer for a 9-bit, 8-opcode instruction set.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instruction_fetch_decode #(
  parameter int PC_WIDTH = 8,
  parameter int RESET_PC = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [8:0]          instrData,
  input  logic                zeroFlag,
  output logic [PC_WIDTH-1:0] instrAddr,
  output logic [2:0]          readRegister1,
  output logic [2:0]          readRegister2,
  output logic                immediate,
  output logic [7:0]          ltValue,
  output logic [1:0]          aluOp,
  output logic                regWrite,
  output logic                busy,
  output logic                done
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_FETCH  = 3'd1;
  localparam logic [2:0] c_DECODE = 3'd2;
  localparam logic [2:0] c_EXEC   = 3'd3;
  localparam logic [2:0] c_HALT   = 3'd4;

  localparam logic [2:0] c_OP_LDI  = 3'b100;
  localparam logic [2:0] c_OP_BRZ  = 3'b101;
  localparam logic [2:0] c_OP_JMP  = 3'b110;
  localparam logic [2:0] c_OP_HALT = 3'b111;

  localparam logic [PC_WIDTH-1:0] c_RESET_PC = RESET_PC[PC_WIDTH-1:0];
  localparam logic [PC_WIDTH-1:0] c_PC_ONE   = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [8:0]          ir_q, ir_d;
  logic                imm_q, imm_d;
  logic [7:0]          lt_q, lt_d;
  logic [1:0]          alu_q, alu_d;
  logic                rw_q, rw_d;

  logic [2:0]          w_dec_op;
  logic [2:0]          w_exec_op;
  logic [PC_WIDTH-1:0] w_offset;
  logic                w_take;

  assign w_dec_op  = instrData[8:6];
  assign w_exec_op = ir_q[8:6];
  // Branch/jump offset is a signed 3-bit field, sign-extended to PC width.
  assign w_offset  = {{(PC_WIDTH-3){ir_q[2]}}, ir_q[2:0]};
  assign w_take    = (w_exec_op == c_OP_JMP) || ((w_exec_op == c_OP_BRZ) && zeroFlag);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    lt_d    = lt_q;
    alu_d   = alu_q;
    rw_d    = rw_q;
    case (state_q)
      c_IDLE: begin
        if (start) state_d = c_FETCH;
      end
      c_FETCH: begin
        state_d = c_DECODE;
      end
      c_DECODE: begin
        state_d = c_EXEC;
        ir_d    = instrData;
        rw_d    = !w_dec_op[2] || (w_dec_op == c_OP_LDI);
        imm_d   = (w_dec_op == c_OP_LDI);
        lt_d    = (w_dec_op == c_OP_LDI) ? {5'b00000, instrData[2:0]} : 8'h00;
        alu_d   = w_dec_op[2] ? 2'b00 : w_dec_op[1:0];
      end
      c_EXEC: begin
        rw_d = 1'b0;
        if (w_exec_op == c_OP_HALT) begin
          state_d = c_HALT;
        end else begin
          state_d = c_FETCH;
          pc_d    = w_take ? (pc_q + w_offset) : (pc_q + c_PC_ONE);
        end
      end
      c_HALT: begin
        if (start) begin
          state_d = c_FETCH;
          pc_d    = c_RESET_PC;
        end
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= c_IDLE;
      pc_q    <= c_RESET_PC;
      ir_q    <= 9'd0;
      imm_q   <= 1'b0;
      lt_q    <= 8'h00;
      alu_q   <= 2'b00;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      lt_q    <= lt_d;
      alu_q   <= alu_d;
      rw_q    <= rw_d;
    end
  end

  assign instrAddr     = pc_q;
  assign readRegister1 = ir_q[5:3];
  assign readRegister2 = ir_q[2:0];
  assign immediate     = imm_q;
  assign ltValue       = lt_q;
  assign aluOp         = alu_q;
  assign regWrite      = rw_q;
  assign busy          = (state_q == c_FETCH) || (state_q == c_DECODE) || (state_q == c_EXEC);
  assign done          = (state_q == c_HALT);

endmodule

`default_nettype wire

// File: doc/instruction_fetch_decode.md
INSTRUCTION_FETCH_DECODE -- requirements
Module: instruction_fetch_decode

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8, meaning the program counter and instruction address width.
REQ-002 SHALL have parameter RESET_PC, default 0, meaning the PC value loaded on reset and on restart.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  begins execution; sampled in IDLE and HALT only.
REQ-007 instrData  input  9  instruction from instruction memory; valid one cycle after instrAddr is presented.
REQ-008 zeroFlag  input  1  ALU zero flag; sampled in EXEC.
REQ-009 instrAddr  output  PC_WIDTH  current PC driven to instruction memory.
REQ-010 readRegister1  output  3  destination/first source index (instr[5:3]).
REQ-011 readRegister2  output  3  second source index (instr[2:0]).
REQ-012 immediate  output  1  selects ltValue as the second operand.
REQ-013 ltValue  output  8  zero-extended immediate {5'b0, instr[2:0]}.
REQ-014 aluOp  output  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 XOR.
REQ-015 regWrite  output  1  register-file write enable.
REQ-016 busy  output  1  high in FETCH, DECODE and EXEC.
REQ-017 done  output  1  high in HALT.

Function
REQ-018 SHALL use the opcode field instr[8:6]: 000 ADD, 001 SUB, 010 AND, 011 XOR, 100 LDI, 101 BRZ, 110 JMP, 111 HALT.
REQ-019 SHALL implement the states IDLE, FETCH, DECODE, EXEC and HALT; each instruction takes exactly 3 cycles (FETCH, DECODE, EXEC).
REQ-020 IDLE: start=1 -> FETCH; otherwise stay in IDLE.
REQ-021 FETCH: instrAddr=PC; the state always goes to DECODE.
REQ-022 DECODE: SHALL capture instrData into the instruction register; decoded outputs SHALL be registered and become valid in the following EXEC cycle.
REQ-023 In EXEC, regWrite SHALL be 1 for opcodes 000-100 and 0 otherwise; regWrite SHALL be 0 in every other state.
REQ-024 For LDI: immediate=1, aluOp=00, ltValue={5'b0, instr[2:0]}.
REQ-025 For all other opcodes: immediate=0 and ltValue=0.
REQ-026 At the end of EXEC, the next PC SHALL be PC + sext(instr[2:0]) for JMP, or for BRZ when zeroFlag=1; otherwise it SHALL be PC+1.
REQ-027 PC arithmetic SHALL be modulo 2^PC_WIDTH: 0xFF+1 wraps to 0x00, and 0x00+(-1) wraps to 0xFF.
REQ-028 A branch offset of 0 (a self-loop) SHALL be legal and re-execute the same address.
REQ-029 EXEC of HALT SHALL go to HALT without advancing PC; all other opcodes go from EXEC to FETCH.
REQ-030 HALT: done=1 is held; start=1 reloads PC=RESET_PC and goes to FETCH.
REQ-031 start while busy SHALL be ignored.
REQ-032 instrAddr SHALL always equal PC, including when not in FETCH.

Reset
REQ-033 Reset SHALL immediately force state=IDLE, PC=RESET_PC, instruction register=0 and all outputs=0, including mid-instruction; a pending regWrite SHALL be dropped.
REQ-034 After reset deasserts, the block SHALL remain in IDLE until start=1.

Verification
REQ-035 Reset, then start pulse, memory[0]=9'b100_010_101 (LDI r2,5) -> the EXEC cycle is 3 cycles after start with regWrite=1, readRegister1=2, immediate=1, ltValue=0x05; the next FETCH has instrAddr=1.
REQ-036 memory[4]=BRZ offset -2 with zeroFlag=1 -> next instrAddr=2; repeat with zeroFlag=0 -> next instrAddr=5.
REQ-037 PC=0xFF holding ADD -> next instrAddr=0x00; PC=0x00 holding JMP -1 -> next instrAddr=0xFF.
REQ-038 HALT at address 3 -> done=1, busy=0, instrAddr stays 3; start -> instrAddr=RESET_PC, busy=1.
REQ-039 Assert reset during EXEC of an ADD -> regWrite falls the same cycle, state=IDLE, instrAddr=0, done=0.
REQ-040 Pulse start in DECODE -> no effect on sequencing or PC.
